// File: rtl/ccip_rd_scheduler.sv
// ccip_rd_scheduler
// Shares the CCI-P C0Tx read-request channel among NUM_REQ requesters using
// round-robin arbitration. Each issued read takes an mdata tag from a fixed
// pool, and that pool bounds the number of reads in flight. A request is held
// back while its cache-line address matches a read that is still in flight.
// Each C0Rx response is routed back to the requester that issued the read.
module ccip_rd_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ADDR_WIDTH      = 42,
    parameter int TAG_WIDTH       = 3
) (
    input  logic                          clk,
    input  logic                          sys_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          C0TxRdValid,
    output logic [ADDR_WIDTH-1:0]         C0TxAddr,
    output logic [TAG_WIDTH-1:0]          C0TxMdata,
    input  logic                          C0TxAlmFull,
    input  logic                          C0RxRdValid,
    input  logic [TAG_WIDTH-1:0]          C0RxMdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [TAG_WIDTH:0]            outstanding_cnt,
    output logic                          hazard_stall,
    output logic                          err_spurious
);

    localparam int OWNER_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Tag table: one entry per mdata tag
    logic [MAX_OUTSTANDING-1:0] tagValid;
    logic [ADDR_WIDTH-1:0]      tagAddr  [MAX_OUTSTANDING];
    logic [OWNER_WIDTH-1:0]     tagOwner [MAX_OUTSTANDING];

    // Round-robin pointer: the requester that gets first look next cycle
    logic [OWNER_WIDTH-1:0]     rrPtr;

    logic [NUM_REQ-1:0]         addrHit;
    logic                       anyFree;
    logic [TAG_WIDTH-1:0]       freeTag;
    logic                       issueOk;
    logic [NUM_REQ-1:0]         eligible;
    logic [NUM_REQ-1:0]         grantVec;
    logic                       grantAny;
    logic [OWNER_WIDTH-1:0]     grantIdx;
    logic [ADDR_WIDTH-1:0]      grantAddr;
    logic [OWNER_WIDTH-1:0]     nextPtr;
    int                         scanIdx;
    logic                       rxHit;
    logic [OWNER_WIDTH-1:0]     rxOwner;
    logic [NUM_REQ-1:0]         rspNext;
    logic                       hazardNext;

    // Compare every requester address against every in-flight entry (pre-edge table)
    always_comb begin
        addrHit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                if (tagValid[t] && (tagAddr[t] == req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    addrHit[i] = 1'b1;
                end
            end
        end
    end

    // Find the lowest-index free tag; scanning downward lets the lowest one win
    always_comb begin
        anyFree = 1'b0;
        freeTag = '0;
        for (int t = MAX_OUTSTANDING - 1; t >= 0; t--) begin
            if (!tagValid[t]) begin
                anyFree = 1'b1;
                freeTag = TAG_WIDTH'(t);
            end
        end
    end

    assign issueOk  = anyFree && !C0TxAlmFull;
    assign eligible = req_valid & ~addrHit & {NUM_REQ{issueOk}};

    // Round-robin scan from rrPtr upward, wrapping, for the first eligible requester
    always_comb begin
        grantVec = '0;
        grantAny = 1'b0;
        grantIdx = '0;
        scanIdx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = int'(rrPtr) + k;
            if (scanIdx >= NUM_REQ) begin
                scanIdx = scanIdx - NUM_REQ;
            end
            if (!grantAny && eligible[scanIdx]) begin
                grantAny          = 1'b1;
                grantIdx          = OWNER_WIDTH'(scanIdx);
                grantVec[scanIdx] = 1'b1;
            end
        end
    end

    assign req_ready = grantVec;
    assign grantAddr = req_addr[int'(grantIdx)*ADDR_WIDTH +: ADDR_WIDTH];

    // Pointer moves to the requester just after the one granted
    always_comb begin
        nextPtr = rrPtr;
        if (grantAny) begin
            if (grantIdx == OWNER_WIDTH'(NUM_REQ - 1)) begin
                nextPtr = '0;
            end else begin
                nextPtr = grantIdx + OWNER_WIDTH'(1);
            end
        end
    end

    // Decode the response tag and prepare the one-hot indication for its owner
    always_comb begin
        rxHit   = C0RxRdValid && tagValid[C0RxMdata];
        rxOwner = tagOwner[C0RxMdata];
        rspNext = '0;
        if (rxHit) begin
            rspNext[rxOwner] = 1'b1;
        end
    end

    // Stall flag: a requester lost only because of an address match
    assign hazardNext = !grantAny && issueOk && (|(req_valid & addrHit));

    // Tag table update: allocate on handshake, clear on a valid retire
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            tagValid <= '0;
            for (int t = 0; t < MAX_OUTSTANDING; t++) begin
                tagAddr[t]  <= '0;
                tagOwner[t] <= '0;
            end
        end else begin
            if (rxHit) begin
                tagValid[C0RxMdata] <= 1'b0;
            end
            if (grantAny) begin
                tagValid[freeTag] <= 1'b1;
                tagAddr[freeTag]  <= grantAddr;
                tagOwner[freeTag] <= grantIdx;
            end
        end
    end

    // C0Tx issue register; address and tag hold their values when nothing issues
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            C0TxRdValid <= 1'b0;
            C0TxAddr    <= '0;
            C0TxMdata   <= '0;
            rrPtr       <= '0;
        end else begin
            C0TxRdValid <= grantAny;
            rrPtr       <= nextPtr;
            if (grantAny) begin
                C0TxAddr  <= grantAddr;
                C0TxMdata <= freeTag;
            end
        end
    end

    // Outstanding count; a same-cycle allocate and retire cancel out
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            outstanding_cnt <= '0;
        end else begin
            case ({grantAny, rxHit})
                2'b10:   outstanding_cnt <= outstanding_cnt + (TAG_WIDTH+1)'(1);
                2'b01:   outstanding_cnt <= outstanding_cnt - (TAG_WIDTH+1)'(1);
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    // Response routing, hazard flag and sticky spurious-response error
    always_ff @(posedge clk) begin
        if (sys_reset) begin
            rsp_valid    <= '0;
            hazard_stall <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            rsp_valid    <= rspNext;
            hazard_stall <= hazardNext;
            if (C0RxRdValid && !tagValid[C0RxMdata]) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_rd_scheduler.sv
// tb_ccip_rd_scheduler
// Directed bench for ccip_rd_scheduler with hand-computed expectations.
module tb_ccip_rd_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int MAX_OUT    = 8;
    localparam int ADDR_WIDTH = 42;
    localparam int TAG_WIDTH  = 3;

    logic                          clk;
    logic                          sys_reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          C0TxRdValid;
    logic [ADDR_WIDTH-1:0]         C0TxAddr;
    logic [TAG_WIDTH-1:0]          C0TxMdata;
    logic                          C0TxAlmFull;
    logic                          C0RxRdValid;
    logic [TAG_WIDTH-1:0]          C0RxMdata;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [TAG_WIDTH:0]            outstanding_cnt;
    logic                          hazard_stall;
    logic                          err_spurious;

    int checkCount = 0;
    int errorCount = 0;

    ccip_rd_scheduler #(
        .NUM_REQ(NUM_REQ),
        .MAX_OUTSTANDING(MAX_OUT),
        .ADDR_WIDTH(ADDR_WIDTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk),
        .sys_reset(sys_reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .C0TxRdValid(C0TxRdValid),
        .C0TxAddr(C0TxAddr),
        .C0TxMdata(C0TxMdata),
        .C0TxAlmFull(C0TxAlmFull),
        .C0RxRdValid(C0RxRdValid),
        .C0RxMdata(C0RxMdata),
        .rsp_valid(rsp_valid),
        .outstanding_cnt(outstanding_cnt),
        .hazard_stall(hazard_stall),
        .err_spurious(err_spurious)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setAddr(input int idx, input logic [ADDR_WIDTH-1:0] a);
        req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] = a;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic almFull,
                                 input logic rxValid, input logic [TAG_WIDTH-1:0] rxTag);
        req_valid   = valid;
        C0TxAlmFull = almFull;
        C0RxRdValid = rxValid;
        C0RxMdata   = rxTag;
        #1;
    endtask

    task automatic doReset();
        sys_reset = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        tick();
        sys_reset = 1'b0;
    endtask

    initial begin
        req_addr = '0;
        doReset();
        tick();

        // Reset state
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("rst_txvalid", 64'(C0TxRdValid), 64'd0);
        checkOutput("rst_txaddr", 64'(C0TxAddr), 64'd0);
        checkOutput("rst_cnt", 64'(outstanding_cnt), 64'd0);
        checkOutput("rst_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("rst_hazard", 64'(hazard_stall), 64'd0);
        checkOutput("rst_err", 64'(err_spurious), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);

        // Single request
        setAddr(0, 42'h100);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_ready", 64'(req_ready), 64'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t1_txvalid", 64'(C0TxRdValid), 64'd1);
        checkOutput("t1_txaddr", 64'(C0TxAddr), 64'h100);
        checkOutput("t1_txmdata", 64'(C0TxMdata), 64'd0);
        checkOutput("t1_cnt", 64'(outstanding_cnt), 64'd1);

        // Round robin across all four requesters
        doReset();
        for (int i = 0; i < NUM_REQ; i++) setAddr(i, 42'h1000 + 42'(i));
        applyStimulus(4'b1111, 1'b0, 1'b0, 3'd0);
        for (int k = 0; k < NUM_REQ; k++) begin
            checkOutput($sformatf("t2_ready%0d", k), 64'(req_ready), 64'd1 << k);
            tick();
            checkOutput($sformatf("t2_mdata%0d", k), 64'(C0TxMdata), 64'(k));
            checkOutput($sformatf("t2_addr%0d", k), 64'(C0TxAddr), 64'h1000 + 64'(k));
            #1;
        end
        checkOutput("t2_allblocked", 64'(req_ready), 64'd0);
        tick();
        checkOutput("t2_hazard", 64'(hazard_stall), 64'd1);
        checkOutput("t2_noissue", 64'(C0TxRdValid), 64'd0);
        for (int i = 0; i < NUM_REQ; i++) setAddr(i, 42'h2000 + 42'(i));
        #1;
        checkOutput("t2_ptrwrap", 64'(req_ready), 64'h1);
        checkOutput("t2_cnt", 64'(outstanding_cnt), 64'd4);

        // Address hazard and response routing
        doReset();
        setAddr(0, 42'h200);
        setAddr(1, 42'h200);
        applyStimulus(4'b0011, 1'b0, 1'b0, 3'd0);
        checkOutput("t3_ready0", 64'(req_ready), 64'h1);
        tick();
        checkOutput("t3_mdata0", 64'(C0TxMdata), 64'd0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0);
        checkOutput("t3_blocked", 64'(req_ready), 64'd0);
        tick();
        checkOutput("t3_hazard", 64'(hazard_stall), 64'd1);
        applyStimulus(4'b0010, 1'b0, 1'b1, 3'd0);
        checkOutput("t3_blockret", 64'(req_ready), 64'd0);
        tick();
        checkOutput("t3_rsp", 64'(rsp_valid), 64'h1);
        checkOutput("t3_cnt0", 64'(outstanding_cnt), 64'd0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0);
        checkOutput("t3_ready1", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t3_mdata1", 64'(C0TxMdata), 64'd0);
        checkOutput("t3_addr1", 64'(C0TxAddr), 64'h200);
        checkOutput("t3_rspdone", 64'(rsp_valid), 64'd0);
        checkOutput("t3_hazclr", 64'(hazard_stall), 64'd0);

        // Fill the pool, then retire and reuse
        doReset();
        for (int k = 0; k < MAX_OUT; k++) begin
            setAddr(0, 42'h300 + 42'(k));
            applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
            tick();
        end
        checkOutput("t4_lastmdata", 64'(C0TxMdata), 64'd7);
        checkOutput("t4_full", 64'(outstanding_cnt), 64'd8);
        setAddr(0, 42'h400);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_fullready", 64'(req_ready), 64'd0);
        applyStimulus(4'b0001, 1'b0, 1'b1, 3'd5);
        checkOutput("t4_retready", 64'(req_ready), 64'd0);
        tick();
        checkOutput("t4_rsp5", 64'(rsp_valid), 64'h1);
        checkOutput("t4_cnt7", 64'(outstanding_cnt), 64'd7);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_readyagain", 64'(req_ready), 64'h1);
        tick();
        checkOutput("t4_reuse5", 64'(C0TxMdata), 64'd5);
        checkOutput("t4_cnt8", 64'(outstanding_cnt), 64'd8);
        applyStimulus(4'b0000, 1'b0, 1'b1, 3'd2);
        tick();
        checkOutput("t4_cntret2", 64'(outstanding_cnt), 64'd7);
        setAddr(0, 42'h401);
        setAddr(1, 42'h303);
        applyStimulus(4'b0011, 1'b0, 1'b1, 3'd3);
        checkOutput("t4_pairready", 64'(req_ready), 64'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t4_pairmdata", 64'(C0TxMdata), 64'd2);
        checkOutput("t4_pairaddr", 64'(C0TxAddr), 64'h401);
        checkOutput("t4_paircnt", 64'(outstanding_cnt), 64'd7);
        checkOutput("t4_pairrsp", 64'(rsp_valid), 64'h1);

        // Almost-full back-pressure
        doReset();
        setAddr(1, 42'h500);
        applyStimulus(4'b0010, 1'b1, 1'b0, 3'd0);
        checkOutput("t5_almready", 64'(req_ready), 64'd0);
        tick();
        checkOutput("t5_noissue", 64'(C0TxRdValid), 64'd0);
        checkOutput("t5_nohazard", 64'(hazard_stall), 64'd0);
        applyStimulus(4'b0010, 1'b0, 1'b0, 3'd0);
        checkOutput("t5_ready", 64'(req_ready), 64'h2);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t5_issue", 64'(C0TxRdValid), 64'd1);
        checkOutput("t5_addr", 64'(C0TxAddr), 64'h500);

        // Spurious response and mid-traffic reset
        doReset();
        applyStimulus(4'b0000, 1'b0, 1'b1, 3'd6);
        tick();
        checkOutput("t6_err", 64'(err_spurious), 64'd1);
        checkOutput("t6_rsp", 64'(rsp_valid), 64'd0);
        setAddr(0, 42'h600);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t6_cnt1", 64'(outstanding_cnt), 64'd1);
        checkOutput("t6_errsticky", 64'(err_spurious), 64'd1);
        doReset();
        #1;
        checkOutput("t6_rstcnt", 64'(outstanding_cnt), 64'd0);
        checkOutput("t6_rsterr", 64'(err_spurious), 64'd0);
        checkOutput("t6_rsttx", 64'(C0TxRdValid), 64'd0);
        applyStimulus(4'b0000, 1'b0, 1'b1, 3'd0);
        tick();
        checkOutput("t6_discarded", 64'(err_spurious), 64'd1);
        checkOutput("t6_discrsp", 64'(rsp_valid), 64'd0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 3'd0);
        checkOutput("t6_tblclear", 64'(req_ready), 64'h1);
        tick();
        applyStimulus(4'b0000, 1'b0, 1'b0, 3'd0);
        checkOutput("t6_mdata", 64'(C0TxMdata), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
